// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: sequencer between a strobed serial front end and an 8-bit
// SIPO shift register. It forwards each accepted bit to the SIPO as a
// registered one-cycle shift pulse and counts the bits of the frame. When the
// frame is complete it captures the SIPO parallel word into a 1-entry
// valid/ready holding buffer.
// Optional build macro: PARITY_FRAME_EN. When it is defined, a frame is WIDTH
// data bits followed by one even-parity bit, and the module has a parity_err
// output.
// state_dbg shows the current FSM state (IDLE=0, SHIFT=1, CAPTURE=2, PARITY=3).
module sipo_frame_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             sipo_shift,
  output logic             sipo_serial,
  input  logic [WIDTH-1:0] sipo_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic             busy,
`ifdef PARITY_FRAME_EN
  output logic             parity_err,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
`ifdef PARITY_FRAME_EN
    , PARITY = 2'd3
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          cap_wait, cap_wait_nxt;
  logic          shift_now;
  logic          load;
  logic          timeout_evt;
  logic          overrun_evt;
`ifdef PARITY_FRAME_EN
  logic          par_acc, par_acc_nxt;
  logic          parity_evt;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // The load happens on the second CAPTURE edge. At that edge a bit strobed
  // in the first CAPTURE cycle has not shifted into the SIPO yet, so
  // sipo_data still holds the finished frame.
  assign overrun_evt = load & data_valid & ~data_ready;

  // FSM state, bit counter, inter-bit timer and capture wait flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      timer    <= '0;
      cap_wait <= 1'b0;
`ifdef PARITY_FRAME_EN
      par_acc  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      timer    <= timer_nxt;
      cap_wait <= cap_wait_nxt;
`ifdef PARITY_FRAME_EN
      par_acc  <= par_acc_nxt;
`endif
    end
  end

  // Next-state logic: accepting bits, completing frames and aborting on timeout
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    timer_nxt    = timer;
    cap_wait_nxt = cap_wait;
    shift_now    = 1'b0;
    load         = 1'b0;
    timeout_evt  = 1'b0;
`ifdef PARITY_FRAME_EN
    par_acc_nxt  = par_acc;
    parity_evt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bit_valid) begin
          shift_now = 1'b1;
          state_nxt = SHIFT;
          count_nxt = CW'(1);
          timer_nxt = '0;
`ifdef PARITY_FRAME_EN
          par_acc_nxt = bit_in;
`endif
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_now = 1'b1;
          timer_nxt = '0;
          count_nxt = count + CW'(1);
`ifdef PARITY_FRAME_EN
          par_acc_nxt = par_acc ^ bit_in;
          if (count == CW'(WIDTH - 1)) state_nxt = PARITY;
`else
          if (count == CW'(WIDTH - 1)) begin
            state_nxt    = CAPTURE;
            cap_wait_nxt = 1'b1;
            count_nxt    = '0;
          end
`endif
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          count_nxt   = '0;
          timer_nxt   = '0;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
`ifdef PARITY_FRAME_EN
      PARITY: begin
        // The parity bit is checked but never shifted into the SIPO.
        if (bit_valid) begin
          parity_evt   = par_acc ^ bit_in;
          state_nxt    = CAPTURE;
          cap_wait_nxt = 1'b1;
          count_nxt    = '0;
          timer_nxt    = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          count_nxt   = '0;
          timer_nxt   = '0;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
`endif
      CAPTURE: begin
        // Bits arriving here already belong to the next frame.
        if (bit_valid) begin
          shift_now = 1'b1;
          timer_nxt = '0;
          count_nxt = count + CW'(1);
`ifdef PARITY_FRAME_EN
          par_acc_nxt = (count == '0) ? bit_in : (par_acc ^ bit_in);
`endif
        end else if (timer != TW'(TIMEOUT - 1)) begin
          timer_nxt = timer + TW'(1);
        end
        if (cap_wait) begin
          cap_wait_nxt = 1'b0;
        end else begin
          load      = 1'b1;
          state_nxt = (count_nxt != '0) ? SHIFT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // Registered SIPO drive: one shift pulse in the cycle after each accepted data bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sipo_shift  <= 1'b0;
      sipo_serial <= 1'b0;
    end else begin
      sipo_shift  <= shift_now;
      sipo_serial <= shift_now & bit_in;
    end
  end

  // Output holding buffer. Valid/ready: a word transfers on any edge where
  // data_valid && data_ready. While data_valid is high, data_out stays
  // stable. If a load and a transfer happen on the same edge, the new word
  // replaces the old one. If the buffer is full and not consumed at load
  // time, the new word is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (load && !overrun_evt) begin
      data_out   <= sipo_data;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky error flags: an error event on the same edge as err_clr keeps the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PARITY_FRAME_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      overrun     <= overrun_evt | (overrun & ~err_clr);
      timeout_err <= timeout_evt | (timeout_err & ~err_clr);
`ifdef PARITY_FRAME_EN
      parity_err  <= parity_evt | (parity_err & ~err_clr);
`endif
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Testbench for sipo_frame_ctrl. The bench models the external SIPO register
// and keeps a frame-level reference model: a bit queue, a word queue, a
// two-cycle load latency and a one-entry consumer buffer.
module tb_sipo_frame_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
`ifdef PARITY_FRAME_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             bit_valid, bit_in, data_ready, err_clr;
  logic             sipo_shift, sipo_serial;
  logic [WIDTH-1:0] sipo_data, data_out;
  logic             data_valid, overrun, timeout_err, busy;
  logic [1:0]       state_dbg;
`ifdef PARITY_FRAME_EN
  logic             parity_err;
`endif

  logic [WIDTH-1:0] sipo_reg = '0;

  int n_checks = 0;
  int n_bad    = 0;

  // reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_acc, m_word;
  int               m_cnt, m_gap, m_cd;
  logic             m_valid, m_ovr, m_to, m_perr;
  logic             exp_shift, exp_serial;

  // clock / reset block
  always #5 clk = ~clk;

  // external SIPO register: MSB-first, shifts left on each pulse
  always @(posedge clk) if (sipo_shift) sipo_reg <= {sipo_reg[WIDTH-2:0], sipo_serial};
  assign sipo_data = sipo_reg;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .sipo_shift(sipo_shift), .sipo_serial(sipo_serial), .sipo_data(sipo_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy),
`ifdef PARITY_FRAME_EN
    .parity_err(parity_err),
`endif
    .state_dbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_gap = 0; m_cd = 0;
    m_valid = 0; m_word = '0; m_acc = '0;
    m_ovr = 0; m_to = 0; m_perr = 0;
    exp_shift = 0; exp_serial = 0;
  endtask

  task automatic check_outputs();
    check_eq("data_valid", 32'(data_valid), 32'(m_valid));
    check_eq("data_out", 32'(data_out), 32'(m_word));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_to));
    check_eq("busy", 32'(busy), 32'((m_cnt > 0) || (m_cd > 0)));
    check_eq("sipo_shift", 32'(sipo_shift), 32'(exp_shift));
    check_eq("sipo_serial", 32'(sipo_serial), 32'(exp_serial));
`ifdef PARITY_FRAME_EN
    check_eq("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  // Advances the model by the edge that is coming next, using the inputs that are about to be driven.
  task automatic model_step(input logic bv, input logic bi, input logic dr, input logic clr);
    logic ld, to_ev, pe, ov_ev;
    logic [WIDTH-1:0] w;
    ld = 0; to_ev = 0; pe = 0; ov_ev = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) ld = 1;
    end
    if (ld) begin
      w = exp_q.pop_front();
      if (m_valid && !dr) ov_ev = 1;
      else begin
        m_word  = w;
        m_valid = 1;
      end
    end else if (m_valid && dr) begin
      m_valid = 0;
    end
    exp_shift  = 0;
    exp_serial = 0;
    if (bv) begin
      m_gap = 0;
      if (m_cnt < WIDTH) begin
        exp_shift  = 1;
        exp_serial = bi;
        m_acc = {m_acc[WIDTH-2:0], bi};
      end
`ifdef PARITY_FRAME_EN
      else pe = (^m_acc) ^ bi;
`endif
      m_cnt++;
      if (m_cnt == FRAME) begin
        exp_q.push_back(m_acc);
        m_cnt = 0;
        m_cd  = 2;
      end
    end else if (m_cnt > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        to_ev = 1;
        m_cnt = 0;
        m_gap = 0;
      end
    end
    m_ovr  = ov_ev | (m_ovr & ~clr);
    m_to   = to_ev | (m_to & ~clr);
    m_perr = pe | (m_perr & ~clr);
  endtask

  // driver: one clock cycle; inputs change on the falling edge, outputs are checked on the next falling edge
  task automatic cyc(input logic bv, input logic bi, input logic dr, input logic clr);
    model_step(bv, bi, dr, clr);
    bit_valid  = bv;
    bit_in     = bi;
    data_ready = dr;
    err_clr    = clr;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input int gap, input logic dr);
    for (int i = WIDTH - 1; i >= WIDTH - nbits; i--) begin
      cyc(1'b1, w[i], dr, 1'b0);
      for (int g = 1; g < gap; g++) cyc(1'b0, 1'b0, dr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input logic dr, input logic bad_par);
    send_bits(w, WIDTH, gap, dr);
`ifdef PARITY_FRAME_EN
    cyc(1'b1, (^w) ^ bad_par, dr, 1'b0);
    for (int g = 1; g < gap; g++) cyc(1'b0, 1'b0, dr, 1'b0);
`else
    if (bad_par) cyc(1'b0, 1'b0, dr, 1'b0);
`endif
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, dr, 1'b0);
  endtask

  initial begin
    reset = 1'b0; bit_valid = 0; bit_in = 0; data_ready = 0; err_clr = 0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs();

    // alternating pattern, one strobe every 2 clocks, consumer always ready
    send_frame(8'b10101010, 2, 1'b1, 1'b0);
    idle(4, 1'b1);

    // two frames with the consumer stalled: first word held, second word lost
    send_frame(8'h3C, 1, 1'b0, 1'b0);
    send_frame(8'hC3, 1, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // partial frame followed by a long silence
    send_bits(8'hF8, 5, 1, 1'b1);
    idle(70, 1'b1);
    send_frame(8'h5A, 1, 1'b1, 1'b0);
    idle(4, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // reset in the middle of a frame
    send_bits(8'hF0, 4, 1, 1'b1);
    #2 reset = 1'b0;
    bit_valid = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
    send_frame(8'h96, 1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // back-to-back frames: the first bit of frame 2 arrives during CAPTURE
    send_frame(8'hE1, 1, 1'b1, 1'b0);
    send_frame(8'h7E, 1, 1'b1, 1'b0);
    idle(4, 1'b1);

`ifdef PARITY_FRAME_EN
    // correct and wrong parity on 8'hA5
    send_frame(8'hA5, 1, 1'b1, 1'b0);
    idle(4, 1'b1);
    send_frame(8'hA5, 1, 1'b1, 1'b1);
    idle(4, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
`endif

    // random stimulus
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 4));
    end
    idle(6, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
